// File: rtl/t08_display_bus_writer.sv
//==============================================================================
// Module   : t08_display_bus_writer
// Brief    : Buffers command/data bytes in a small FIFO and writes them onto an
//            8080-style parallel display bus with programmable strobe widths.
//            Optional macro T08_DISP_LEVEL_EN adds the fifo_level output.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module t08_display_bus_writer #(
    parameter int DEPTH          = 4,
    parameter int WR_LOW_CYCLES  = 2,
    parameter int WR_HIGH_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [7:0]                wr_data,
    input  logic                      wr_is_cmd,
    output logic                      busy,
    output logic [7:0]                spi_outputs,
    output logic                      spi_wrx,
    output logic                      spi_rdx,
    output logic                      spi_csx,
    output logic                      spi_dcx
`ifdef T08_DISP_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]    fifo_level
`endif
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_MAX = (WR_LOW_CYCLES > WR_HIGH_CYCLES) ? WR_LOW_CYCLES : WR_HIGH_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] c_low_last  = CNT_W'(WR_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_high_last = CNT_W'(WR_HIGH_CYCLES - 1);
    localparam logic [PTR_W:0]   c_depth     = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_WR_LOW  = 2'd2,
        ST_WR_HIGH = 2'd3
    } state_t;

    // FIFO storage: bit 8 = is_cmd, bits 7:0 = byte
    logic [8:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [8:0]       w_head;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_csx_nxt;
    logic             w_wrx_nxt;

    assign w_full   = (r_count == c_depth);
    assign w_empty  = (r_count == '0);
    // Full blocks pushes even if a pop frees a slot this cycle: no bypass path.
    assign wr_ready = !w_full;
    assign w_push   = wr_valid && !w_full;
    assign w_head   = r_mem[r_rd_ptr];
    assign busy     = (r_state != ST_IDLE) || !w_empty;
    // Write-only bus: read strobe never asserts.
    assign spi_rdx  = 1'b1;

`ifdef T08_DISP_LEVEL_EN
    assign fifo_level = r_count;
`endif

    // FIFO payload write; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {wr_is_cmd, wr_data};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Strobe sequencer: next state, cycle counter, strobe levels and pop request
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_csx_nxt   = spi_csx;
        w_wrx_nxt   = spi_wrx;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_csx_nxt = 1'b1;
                w_wrx_nxt = 1'b1;
                w_cnt_nxt = '0;
                if (en && !w_empty) begin
                    w_pop       = 1'b1;
                    w_csx_nxt   = 1'b0;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_wrx_nxt   = 1'b0;
                w_cnt_nxt   = '0;
                w_state_nxt = ST_WR_LOW;
            end
            ST_WR_LOW: begin
                if (r_cnt == c_low_last) begin
                    w_wrx_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_WR_HIGH;
                end
            end
            ST_WR_HIGH: begin
                if (r_cnt == c_high_last) begin
                    w_cnt_nxt = '0;
                    // Burst continues with csx held low while words remain.
                    if (en && !w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_SETUP;
                    end else begin
                        w_csx_nxt   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_csx_nxt   = 1'b1;
                w_wrx_nxt   = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered state and bus outputs; data/dcx only change when a word is popped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            spi_csx     <= 1'b1;
            spi_wrx     <= 1'b1;
            spi_dcx     <= 1'b1;
            spi_outputs <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            spi_csx <= w_csx_nxt;
            spi_wrx <= w_wrx_nxt;
            if (w_pop) begin
                spi_outputs <= w_head[7:0];
                spi_dcx     <= !w_head[8];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_t08_display_bus_writer.sv
//==============================================================================
// Module   : tb_t08_display_bus_writer
// Brief    : Self-checking bench for t08_display_bus_writer. A queue of accepted
//            bytes is the reference: every write strobe must latch the oldest
//            outstanding byte with the right dcx, strobe widths and chip select.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_t08_display_bus_writer;

    localparam int DEPTH = 4;
    localparam int WL    = 2;
    localparam int WH    = 2;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       en        = 1'b0;
    logic       wr_valid  = 1'b0;
    logic [7:0] wr_data   = 8'h00;
    logic       wr_is_cmd = 1'b0;
    logic       wr_ready;
    logic       busy;
    logic [7:0] spi_outputs;
    logic       spi_wrx;
    logic       spi_rdx;
    logic       spi_csx;
    logic       spi_dcx;
`ifdef T08_DISP_LEVEL_EN
    logic [LVL_W-1:0] fifo_level;
`endif

    t08_display_bus_writer #(
        .DEPTH          (DEPTH),
        .WR_LOW_CYCLES  (WL),
        .WR_HIGH_CYCLES (WH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .wr_is_cmd   (wr_is_cmd),
        .busy        (busy),
        .spi_outputs (spi_outputs),
        .spi_wrx     (spi_wrx),
        .spi_rdx     (spi_rdx),
        .spi_csx     (spi_csx),
        .spi_dcx     (spi_dcx)
`ifdef T08_DISP_LEVEL_EN
        ,
        .fifo_level  (fifo_level)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: bytes accepted by the FIFO and not yet seen on the bus, {is_cmd, data}
    logic [8:0] exp_q[$];

    int cyc       = 0;
    int rise_cnt  = 0;
    int csx_falls = 0;
    int rise_t[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic c);
        int   waited;
        logic acc;
        waited    = 0;
        wr_valid  = 1'b1;
        wr_data   = d;
        wr_is_cmd = c;
        do begin
            acc = wr_ready;
            @(posedge clk);
            #1;
            waited++;
        end while (!acc && waited < 500);
        if (acc) exp_q.push_back({c, d});
        else     chk("push_accept_timeout", {31'd0, acc}, 32'd1);
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while ((busy || !spi_csx) && c < budget) begin
            tick();
            c++;
        end
        chk("idle_within_budget", {31'd0, (c < budget)}, 32'd1);
    endtask

    task automatic wait_wrx(input logic val, input int budget);
        int c;
        c = 0;
        while (spi_wrx !== val && c < budget) begin
            tick();
            c++;
        end
        chk("wrx_level_within_budget", {31'd0, spi_wrx}, {31'd0, val});
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Bus monitor: checks each strobe's widths and the byte latched on its rising edge
    initial begin
        logic       p_wrx;
        logic       p_csx;
        int         lo_cnt;
        int         hi_cnt;
        bit         burst;
        logic [8:0] e;
        p_wrx  = 1'b1;
        p_csx  = 1'b1;
        lo_cnt = 0;
        hi_cnt = 0;
        burst  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                p_wrx = 1'b1;
                p_csx = 1'b1;
            end else begin
                if (p_csx && !spi_csx) begin
                    csx_falls++;
                    hi_cnt = 1;
                    burst  = 1'b0;
                end else if (p_wrx && !spi_wrx) begin
                    chk("strobe_setup_or_high_width", hi_cnt, burst ? (WH + 1) : 1);
                    lo_cnt = 1;
                end else if (!p_wrx && spi_wrx) begin
                    chk("strobe_low_width", lo_cnt, WL);
                    rise_cnt++;
                    rise_t.push_back(cyc);
                    chk("csx_low_at_latch", {31'd0, spi_csx}, 32'd0);
                    chk("rdx_high", {31'd0, spi_rdx}, 32'd1);
                    chk("write_expected", {31'd0, (exp_q.size() > 0)}, 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("latched_byte", {24'd0, spi_outputs}, {24'd0, e[7:0]});
                        chk("latched_dcx", {31'd0, spi_dcx}, {31'd0, !e[8]});
                    end
                    hi_cnt = 1;
                    burst  = 1'b1;
                end else if (!spi_wrx) begin
                    lo_cnt++;
                end else if (!spi_csx) begin
                    hi_cnt++;
                end
                p_wrx = spi_wrx;
                p_csx = spi_csx;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int f0;
        int c;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", {24'd0, spi_outputs}, 32'd0);
        chk("rst_wrx", {31'd0, spi_wrx}, 32'd1);
        chk("rst_rdx", {31'd0, spi_rdx}, 32'd1);
        chk("rst_csx", {31'd0, spi_csx}, 32'd1);
        chk("rst_dcx", {31'd0, spi_dcx}, 32'd1);
        chk("rst_ready", {31'd0, wr_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
`ifdef T08_DISP_LEVEL_EN
        chk("rst_level", {{(32-LVL_W){1'b0}}, fifo_level}, 32'd0);
`endif
        rst = 1'b0;
        tick();

        // 1: reset during WR_LOW with one byte in flight and three queued
        en = 1'b1;
        push(8'hA1, 1'b1);
        push(8'hA2, 1'b0);
        push(8'hA3, 1'b0);
        push(8'hA4, 1'b0);
        wait_wrx(1'b0, 50);
        #2;
        rst = 1'b1;
        #1;
        chk("t1_async_wrx", {31'd0, spi_wrx}, 32'd1);
        chk("t1_async_csx", {31'd0, spi_csx}, 32'd1);
        chk("t1_async_dcx", {31'd0, spi_dcx}, 32'd1);
        chk("t1_async_out", {24'd0, spi_outputs}, 32'd0);
        chk("t1_async_busy", {31'd0, busy}, 32'd0);
        chk("t1_async_ready", {31'd0, wr_ready}, 32'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        base = rise_cnt;
        repeat (20) tick();
        chk("t1_busy_after", {31'd0, busy}, 32'd0);
        chk("t1_no_writes", rise_cnt - base, 32'd0);

        // 2: single command, cycle-accurate strobe timing relative to push edge N
        chk("t2_ready", {31'd0, wr_ready}, 32'd1);
        wr_valid  = 1'b1;
        wr_data   = 8'h2C;
        wr_is_cmd = 1'b1;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        exp_q.push_back({1'b1, 8'h2C});
        for (int k = 0; k <= 2 + WL + WH + 2; k++) begin
            chk("t2_csx", {31'd0, spi_csx}, (k >= 1 && k < 2 + WL + WH) ? 32'd0 : 32'd1);
            chk("t2_wrx", {31'd0, spi_wrx}, (k >= 2 && k < 2 + WL) ? 32'd0 : 32'd1);
            if (k >= 1 && k < 2 + WL + WH) begin
                chk("t2_data", {24'd0, spi_outputs}, 32'h2C);
                chk("t2_dcx", {31'd0, spi_dcx}, 32'd0);
            end
            tick();
        end
        chk("t2_busy_after", {31'd0, busy}, 32'd0);

        // 3: back-to-back burst keeps csx low, one strobe every 1+WL+WH cycles
        base = rise_cnt;
        f0   = csx_falls;
        rise_t.delete();
        push(8'h2C, 1'b1);
        push(8'h12, 1'b0);
        push(8'h34, 1'b0);
        push(8'h56, 1'b0);
        wait_idle(200);
        chk("t3_writes", rise_cnt - base, 32'd4);
        chk("t3_single_select", csx_falls - f0, 32'd1);
        chk("t3_rise_count", rise_t.size(), 32'd4);
        for (int i = 1; i < rise_t.size(); i++) begin
            chk("t3_period", rise_t[i] - rise_t[i-1], 1 + WL + WH);
        end

        // 4: fill the FIFO with en low; fifth byte waits upstream
        en   = 1'b0;
        base = rise_cnt;
        push(8'h41, 1'b1);
        push(8'h42, 1'b0);
        push(8'h43, 1'b0);
        push(8'h44, 1'b0);
        chk("t4_ready_full", {31'd0, wr_ready}, (exp_q.size() >= DEPTH) ? 32'd0 : 32'd1);
        chk("t4_busy", {31'd0, busy}, 32'd1);
`ifdef T08_DISP_LEVEL_EN
        chk("t4_level", {{(32-LVL_W){1'b0}}, fifo_level}, DEPTH);
`endif
        wr_valid  = 1'b1;
        wr_data   = 8'h45;
        wr_is_cmd = 1'b0;
        repeat (3) begin
            tick();
            chk("t4_held", {31'd0, wr_ready}, 32'd0);
        end
        chk("t4_no_writes_while_disabled", rise_cnt - base, 32'd0);
        en = 1'b1;
        push(8'h45, 1'b0);
        wait_idle(300);
        chk("t4_writes", rise_cnt - base, 32'd5);
        chk("t4_drained", exp_q.size(), 32'd0);

        // 5: en dropped during WR_LOW of byte 2 of 4
        base = rise_cnt;
        push(8'h51, 1'b1);
        push(8'h52, 1'b0);
        push(8'h53, 1'b0);
        push(8'h54, 1'b0);
        c = 0;
        while (rise_cnt - base < 1 && c < 100) begin
            tick();
            c++;
        end
        chk("t5_first_write", rise_cnt - base, 32'd1);
        wait_wrx(1'b0, 50);
        #2;
        en = 1'b0;
        c  = 0;
        while (!spi_csx && c < 100) begin
            tick();
            c++;
        end
        chk("t5_csx_released", {31'd0, spi_csx}, 32'd1);
        chk("t5_writes_at_stop", rise_cnt - base, 32'd2);
        chk("t5_busy_queued", {31'd0, busy}, (exp_q.size() > 0) ? 32'd1 : 32'd0);
        chk("t5_queued", exp_q.size(), 32'd2);
        repeat (15) tick();
        chk("t5_paused", rise_cnt - base, 32'd2);
        en = 1'b1;
        wait_idle(200);
        chk("t5_writes_total", rise_cnt - base, 32'd4);

        // 6: ten random bytes with drains in between (pointer wrap-around)
        base = rise_cnt;
        for (int i = 0; i < 10; i++) begin
            push(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 8)) tick();
        end
        wait_idle(400);
        chk("t6_writes", rise_cnt - base, 32'd10);
        chk("t6_drained", exp_q.size(), 32'd0);

        // Random stress: en toggled between pushes, variable gaps
        base = rise_cnt;
        for (int i = 0; i < 60; i++) begin
            en = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(0, 6)) tick();
            en = 1'b1;
            push(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end
        en = 1'b1;
        wait_idle(1000);
        chk("stress_writes", rise_cnt - base, 32'd60);
        chk("stress_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/t08_display_bus_writer.md
Name: t08_display_bus_writer

Overview:
- Downstream stage of t08_top's display path: buffers command/data bytes from the display controller logic.
- Serialises them onto the 8080-style parallel display bus: spi_outputs, spi_wrx, spi_rdx, spi_csx, spi_dcx.
- Write-only: rdx is held inactive.
- Paces every strobe with programmable low/high widths so the panel's timing minimums are met at core clock.

Parameters:
DEPTH, 4, FIFO entries; power of 2, at least 2
WR_LOW_CYCLES, 2, cycles spi_wrx held low per word; at least 1
WR_HIGH_CYCLES, 2, cycles spi_wrx held high after the rising edge; at least 1

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  bus enable; when low, no new word is started
wr_valid  in  1  upstream byte valid
wr_ready  out  1  FIFO can accept a byte (= !full)
wr_data  in  8  byte to send
wr_is_cmd  in  1  1 = command byte (dcx=0), 0 = parameter/pixel byte (dcx=1)
busy  out  1  state != IDLE or FIFO not empty
spi_outputs  out  8  display data bus
spi_wrx  out  1  write strobe, active low; display latches on rising edge
spi_rdx  out  1  read strobe; constant 1
spi_csx  out  1  chip select, active low
spi_dcx  out  1  0 = command, 1 = data

Behaviour:
- Interface fixed: one clock (clk); reset rst is asynchronous and active-high.
- Reset values (asynchronous, and whenever rst is high):
  - FIFO emptied; state = IDLE.
  - spi_outputs = 0; spi_wrx, spi_rdx, spi_csx, spi_dcx = 1.
  - wr_ready = 1; busy = 0.
- Reset asserted mid-word aborts the word immediately; nothing is retained.
- FIFO:
  - Push on wr_valid && wr_ready; stores {wr_is_cmd, wr_data}.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
  - When full, wr_ready = 0 even if a pop occurs that cycle (no same-cycle bypass). A push and a pop in the same cycle when not full leave the count unchanged.
  - wr_valid while not ready: the byte is ignored; upstream holds it.
- FSM states: IDLE, SETUP, WR_LOW, WR_HIGH. The cycle counter resets to 0 on every state entry.
- IDLE:
  - csx = 1, wrx = 1.
  - If en && !empty: pop head; load spi_outputs = data and spi_dcx = !is_cmd; csx -> 0; go to SETUP.
- SETUP:
  - Exactly 1 cycle with data/dcx stable, csx = 0, wrx = 1.
  - Then wrx -> 0; go to WR_LOW.
- WR_LOW:
  - Hold WR_LOW_CYCLES cycles; then wrx -> 1; go to WR_HIGH.
- WR_HIGH:
  - Hold WR_HIGH_CYCLES cycles.
  - At the end, if en && !empty: pop next word, keep csx = 0, go to SETUP (burst).
  - Otherwise csx -> 1, go to IDLE.
- Outputs are registered. spi_outputs and spi_dcx change only on a pop; they are stable from SETUP through WR_HIGH.
- Latency, byte pushed into an empty FIFO at edge N with the FSM in IDLE and en = 1:
  - csx falls at edge N+1.
  - wrx falls at N+2.
  - wrx rises at N+2+WR_LOW_CYCLES.
- Burst period is 1+WR_LOW_CYCLES+WR_HIGH_CYCLES cycles per byte (5 at defaults). csx stays low through the whole burst.
- en deasserted mid-word: the current word completes fully; the FSM then returns to IDLE and FIFO contents are retained. Re-asserting en resumes from IDLE.
- FIFO drains in the middle of a burst: csx deasserts after WR_HIGH. A later push starts a fresh IDLE -> SETUP sequence.

Optional Feature:
T08_DISP_LEVEL_EN
- Defined: adds output port fifo_level, width log2(DEPTH)+1. It carries the registered occupancy count (0..DEPTH), reset value 0.
- Undefined: the port and any logic driving it are absent; the occupancy counter is still used internally for full/empty.

Test Plan:
1. Reset mid-word with a byte in flight and 3 queued: assert rst during WR_LOW.
   - Outputs go to reset values asynchronously, before the next clk edge.
   - After release, busy = 0 and no further wrx pulses occur.
2. Single command: push 0x2C with wr_is_cmd = 1 at edge N.
   - csx falls at N+1 with dcx = 0 and spi_outputs = 0x2C; wrx low N+2..N+4, rises at N+4.
   - csx rises at N+6; busy = 0 afterwards.
3. Burst: push 0x2C (cmd), then 0x12, 0x34, 0x56 (data) back-to-back.
   - 4 wrx rising edges exactly 5 cycles apart with csx continuously low.
   - dcx = 0, 1, 1, 1; latched bytes in order 0x2C, 0x12, 0x34, 0x56.
4. Full FIFO: hold en = 0 and push 5 bytes.
   - wr_ready drops after the 4th push; the 5th is held by upstream.
   - fifo_level = 4 when T08_DISP_LEVEL_EN is defined.
   - Raising en drains all 5 bytes in order.
5. en drop mid-burst: deassert en during WR_LOW of byte 2 of 4.
   - Byte 2 completes and csx rises; bytes 3–4 remain queued (busy = 1).
   - Re-enabling sends them.
6. Pointer wrap-around: 10 pushes interleaved with drains.
   - All 10 bytes appear on spi_outputs in push order; spi_rdx = 1 throughout.
